// File: rtl/pong_pkg.sv
// Shared types and constants for the pong game engine.
package pong_pkg;

  localparam int COORD_W  = 12;  // pixel coordinate width
  localparam int SCOORD_W = 13;  // signed width for motion/collision maths

  typedef enum logic [2:0] {
    IDLE,
    SERVE,
    PLAY,
    POINT,
    GAME_OVER
  } state_t;

  localparam logic [7:0] RGB_BALL   = 8'hE0;
  localparam logic [7:0] RGB_PADDLE = 8'hFF;
  localparam logic [7:0] RGB_NET    = 8'h49;
  localparam logic [7:0] RGB_BG     = 8'h00;

  // Zero-extend an unsigned coordinate into the signed arithmetic domain.
  function automatic logic signed [SCOORD_W-1:0] sx(input logic [COORD_W-1:0] v);
    return $signed({1'b0, v});
  endfunction

endpackage

// File: rtl/pong_paddle_ctrl.sv
// One paddle: moves its centre row once per frame and clamps to the screen.
module pong_paddle_ctrl
  import pong_pkg::*;
#(
  parameter int DISP_ROWS     = 600,
  parameter int PADDLE_HEIGHT = 44,
  parameter int PADDLE_SPEED  = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_tick,
  input  logic               up,
  input  logic               down,
  output logic [COORD_W-1:0] centre
);

  localparam logic [COORD_W-1:0] LO   = COORD_W'(PADDLE_HEIGHT / 2);
  localparam logic [COORD_W-1:0] HI   = COORD_W'(DISP_ROWS - 1 - PADDLE_HEIGHT / 2);
  localparam logic [COORD_W-1:0] STEP = COORD_W'(PADDLE_SPEED);
  localparam logic [COORD_W-1:0] HOME = COORD_W'(DISP_ROWS / 2);

  // Step on frame_tick; an overshooting move lands exactly on the limit.
  always_ff @(posedge clk) begin
    if (rst) begin
      centre <= HOME;
    end else if (frame_tick) begin
      if (up && !down)
        centre <= (centre < LO + STEP) ? LO : centre - STEP;
      else if (down && !up)
        centre <= (centre + STEP > HI) ? HI : centre + STEP;
    end
  end

endmodule

// File: rtl/pong_game_engine.sv
// Pong game state (paddles, ball, scores, FSM) and registered pixel colour.
module pong_game_engine
  import pong_pkg::*;
#(
  parameter int DISP_COLS     = 800,
  parameter int DISP_ROWS     = 600,
  parameter int PADDLE_HEIGHT = 44,
  parameter int PADDLE_WIDTH  = 12,
  parameter int PADDLE_INSET  = 15,
  parameter int PADDLE_SPEED  = 4,
  parameter int BALL_HEIGHT   = 8,
  parameter int BALL_WIDTH    = 6,
  parameter int BALL_SPEED    = 2,
  parameter int SERVE_FRAMES  = 60,
  parameter int WIN_SCORE     = 7
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               move_up_control_p0,
  input  logic               move_down_control_p0,
  input  logic               move_up_control_p1,
  input  logic               move_down_control_p1,
  input  logic               serve,
  input  logic [COORD_W-1:0] col_counter,
  input  logic [COORD_W-1:0] row_counter,
  output logic [7:0]         rgb,
  output logic [3:0]         score_p0,
  output logic [3:0]         score_p1,
  output logic               game_over,
  output logic               winner
);

  localparam int SW    = SCOORD_W;
  localparam int CNT_W = $clog2(SERVE_FRAMES + 1);

  // Ball extent around its centre: [c-W/2, c+W-1-W/2].
  localparam logic signed [SW-1:0] BW2     = SW'(BALL_WIDTH / 2);
  localparam logic signed [SW-1:0] BR_OFF  = SW'(BALL_WIDTH - 1 - BALL_WIDTH / 2);
  localparam logic signed [SW-1:0] BH2     = SW'(BALL_HEIGHT / 2);
  localparam logic signed [SW-1:0] BB_OFF  = SW'(BALL_HEIGHT - 1 - BALL_HEIGHT / 2);
  localparam logic signed [SW-1:0] PH2     = SW'(PADDLE_HEIGHT / 2);
  localparam logic signed [SW-1:0] PB_OFF  = SW'(PADDLE_HEIGHT - 1 - PADDLE_HEIGHT / 2);
  localparam logic signed [SW-1:0] BSPD    = SW'(BALL_SPEED);
  localparam logic signed [SW-1:0] ZERO    = '0;
  localparam logic signed [SW-1:0] COL_MAX = SW'(DISP_COLS - 1);
  localparam logic signed [SW-1:0] BOT_LIM = SW'(DISP_ROWS - 1 - (BALL_HEIGHT - 1 - BALL_HEIGHT / 2));
  // The paddles' inner (ball-facing) faces sit on the inset column from each side.
  localparam logic signed [SW-1:0] LP_R    = SW'(PADDLE_INSET);
  localparam logic signed [SW-1:0] LP_L    = SW'(PADDLE_INSET - PADDLE_WIDTH + 1);
  localparam logic signed [SW-1:0] RP_L    = SW'(DISP_COLS - 1 - PADDLE_INSET);
  localparam logic signed [SW-1:0] RP_R    = SW'(DISP_COLS - 1 - PADDLE_INSET + PADDLE_WIDTH - 1);
  localparam logic signed [SW-1:0] L_SNAP  = SW'(PADDLE_INSET + 1 + BALL_WIDTH / 2);
  localparam logic signed [SW-1:0] R_SNAP  = SW'(DISP_COLS - 1 - PADDLE_INSET - 1 - BALL_WIDTH / 2);

  localparam logic [COORD_W-1:0] HOME_C = COORD_W'(DISP_COLS / 2);
  localparam logic [COORD_W-1:0] HOME_R = COORD_W'(DISP_ROWS / 2);
  localparam logic [3:0]         WIN    = 4'(WIN_SCORE);

  state_t             state;
  logic [COORD_W-1:0] ball_col, ball_row, pad_row0, pad_row1;
  logic               vx_neg, vy_neg, scorer, serve_pend;
  logic [CNT_W-1:0]   serve_cnt;

  logic frame_tick, serve_req;
  assign frame_tick = (col_counter == '0) && (row_counter == COORD_W'(DISP_ROWS));
  assign serve_req  = serve | serve_pend;

  pong_paddle_ctrl #(.DISP_ROWS(DISP_ROWS), .PADDLE_HEIGHT(PADDLE_HEIGHT), .PADDLE_SPEED(PADDLE_SPEED))
    u_pad0 (.clk(clk), .rst(rst), .frame_tick(frame_tick),
            .up(move_up_control_p0), .down(move_down_control_p0), .centre(pad_row0));
  pong_paddle_ctrl #(.DISP_ROWS(DISP_ROWS), .PADDLE_HEIGHT(PADDLE_HEIGHT), .PADDLE_SPEED(PADDLE_SPEED))
    u_pad1 (.clk(clk), .rst(rst), .frame_tick(frame_tick),
            .up(move_up_control_p1), .down(move_down_control_p1), .centre(pad_row1));

  logic signed [SW-1:0] nx, ny, ny_w, nx_f, b_l, b_r, b_t, b_b;
  logic                 vy_neg_n, hit_l, hit_r, miss_l, miss_r;

  // Next ball position with wall snapping, paddle bounces and miss detection.
  always_comb begin
    nx       = sx(ball_col) + (vx_neg ? -BSPD : BSPD);
    ny       = sx(ball_row) + (vy_neg ? -BSPD : BSPD);
    ny_w     = ny;
    vy_neg_n = vy_neg;
    if (ny < BH2) begin
      ny_w     = BH2;
      vy_neg_n = 1'b0;
    end else if (ny > BOT_LIM) begin
      ny_w     = BOT_LIM;
      vy_neg_n = 1'b1;
    end
    b_l    = nx - BW2;
    b_r    = nx + BR_OFF;
    b_t    = ny_w - BH2;
    b_b    = ny_w + BB_OFF;
    hit_l  = vx_neg && (b_l <= LP_R) && (b_r >= LP_L) &&
             (b_t <= sx(pad_row0) + PB_OFF) && (b_b >= sx(pad_row0) - PH2);
    hit_r  = !vx_neg && (b_r >= RP_L) && (b_l <= RP_R) &&
             (b_t <= sx(pad_row1) + PB_OFF) && (b_b >= sx(pad_row1) - PH2);
    miss_l = !hit_l && !hit_r && (b_l <= ZERO);
    miss_r = !hit_l && !hit_r && (b_r >= COL_MAX);
    nx_f   = hit_l ? L_SNAP : (hit_r ? R_SNAP : nx);
  end

  // Game FSM, serve latch, ball motion and scoring; all updates gated by frame_tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ball_col   <= HOME_C;
      ball_row   <= HOME_R;
      vx_neg     <= 1'b0;
      vy_neg     <= 1'b0;
      scorer     <= 1'b0;
      serve_pend <= 1'b0;
      serve_cnt  <= '0;
      score_p0   <= '0;
      score_p1   <= '0;
      game_over  <= 1'b0;
      winner     <= 1'b0;
    end else begin
      if (frame_tick)  serve_pend <= 1'b0;
      else if (serve)  serve_pend <= 1'b1;
      if (frame_tick) begin
        case (state)
          IDLE: begin
            serve_cnt <= '0;
            if (serve_req) state <= SERVE;
          end
          SERVE: begin
            if (serve_cnt == CNT_W'(SERVE_FRAMES - 1)) begin
              state     <= PLAY;
              serve_cnt <= '0;
            end else begin
              serve_cnt <= serve_cnt + 1'b1;
            end
          end
          PLAY: begin
            if (miss_l || miss_r) begin
              state  <= POINT;
              scorer <= miss_l;  // left miss means p1 scored
            end else begin
              ball_col <= COORD_W'(nx_f);
              ball_row <= COORD_W'(ny_w);
              vx_neg   <= hit_r ? 1'b1 : (hit_l ? 1'b0 : vx_neg);
              vy_neg   <= vy_neg_n;
            end
          end
          POINT: begin
            ball_col <= HOME_C;
            ball_row <= HOME_R;
            vx_neg   <= scorer;  // relaunch toward the player who conceded
            if (scorer) score_p1 <= score_p1 + 4'd1;
            else        score_p0 <= score_p0 + 4'd1;
            if ((scorer ? score_p1 : score_p0) + 4'd1 == WIN) begin
              state     <= GAME_OVER;
              game_over <= 1'b1;
              winner    <= scorer;
            end else begin
              state     <= SERVE;
              serve_cnt <= '0;
            end
          end
          GAME_OVER: begin
            if (serve_req) begin
              state     <= SERVE;
              serve_cnt <= '0;
              score_p0  <= '0;
              score_p1  <= '0;
              game_over <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  logic signed [SW-1:0] pc, pr;
  logic                 ball_px, pad_px, net_px;
  logic [7:0]           pix;

  // Object hit-test for the current pixel, priority ball > paddles > net.
  always_comb begin
    pc      = sx(col_counter);
    pr      = sx(row_counter);
    ball_px = (state != GAME_OVER) &&
              (pc >= sx(ball_col) - BW2) && (pc <= sx(ball_col) + BR_OFF) &&
              (pr >= sx(ball_row) - BH2) && (pr <= sx(ball_row) + BB_OFF);
    pad_px  = ((pc >= LP_L) && (pc <= LP_R) &&
               (pr >= sx(pad_row0) - PH2) && (pr <= sx(pad_row0) + PB_OFF)) ||
              ((pc >= RP_L) && (pc <= RP_R) &&
               (pr >= sx(pad_row1) - PH2) && (pr <= sx(pad_row1) + PB_OFF));
    net_px  = (col_counter == HOME_C) && !row_counter[3];
    pix     = RGB_BG;
    if (col_counter < COORD_W'(DISP_COLS) && row_counter < COORD_W'(DISP_ROWS)) begin
      if (ball_px)     pix = RGB_BALL;
      else if (pad_px) pix = RGB_PADDLE;
      else if (net_px) pix = RGB_NET;
    end
  end

  // One-cycle registered colour.
  always_ff @(posedge clk) begin
    if (rst) rgb <= RGB_BG;
    else     rgb <= pix;
  end

endmodule

// File: tb/tb_pong_game_engine.sv
// Directed bench for pong_game_engine: frame ticks are forced through the counters.
module tb_pong_game_engine;
  import pong_pkg::*;

  logic        clk = 1'b0;
  logic        rst, serve, up0, dn0, up1, dn1;
  logic [11:0] col, row;
  logic [7:0]  rgb;
  logic [3:0]  score_p0, score_p1;
  logic        game_over, winner;
  int          checks = 0;
  int          fails  = 0;
  int          n;

  pong_game_engine dut (
    .clk(clk), .rst(rst),
    .move_up_control_p0(up0), .move_down_control_p0(dn0),
    .move_up_control_p1(up1), .move_down_control_p1(dn1),
    .serve(serve), .col_counter(col), .row_counter(row),
    .rgb(rgb), .score_p0(score_p0), .score_p1(score_p1),
    .game_over(game_over), .winner(winner)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // One frame_tick cycle followed by one ordinary visible-pixel cycle.
  task automatic tick();
    col = 12'd0; row = 12'd600;
    @(posedge clk); #1;
    col = 12'd100; row = 12'd100;
    @(posedge clk); #1;
  endtask

  task automatic pix(input string tag, input int c, input int r, input logic [7:0] exp);
    col = 12'(c); row = 12'(r);
    @(posedge clk); #1;
    chk(tag, rgb, exp);
    col = 12'd100; row = 12'd100;
  endtask

  task automatic pulse_serve();
    serve = 1'b1;
    @(posedge clk); #1;
    serve = 1'b0;
  endtask

  initial begin
    rst = 1'b1; serve = 1'b0; up0 = 1'b0; dn0 = 1'b0; up1 = 1'b0; dn1 = 1'b0;
    col = 12'd100; row = 12'd100;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rgb", rgb, 0);
    chk("rst_state", dut.state, IDLE);
    chk("rst_score_p0", score_p0, 0);
    chk("rst_score_p1", score_p1, 0);
    chk("rst_game_over", game_over, 0);
    chk("rst_winner", winner, 0);
    chk("rst_ball_col", dut.ball_col, 400);
    chk("rst_ball_row", dut.ball_row, 300);
    chk("rst_pad0", dut.pad_row0, 300);
    chk("rst_pad1", dut.pad_row1, 300);
    chk("rst_vx_neg", dut.vx_neg, 0);
    chk("rst_vy_neg", dut.vy_neg, 0);
    rst = 1'b0;

    // Idle frame: pixel map at rest
    tick();
    pix("px_paddle0", 15, 300, 8'hFF);
    pix("px_ball", 400, 300, 8'hE0);
    pix("px_net", 400, 0, 8'h49);
    pix("px_net_gap", 400, 8, 8'h00);
    pix("px_paddle1", 784, 300, 8'hFF);
    pix("px_bg", 100, 200, 8'h00);
    pix("px_offscreen_col", 900, 100, 8'h00);
    pix("px_offscreen_row", 15, 650, 8'h00);
    chk("idle_state", dut.state, IDLE);
    chk("idle_ball_col", dut.ball_col, 400);

    // Paddle motion and clamping
    up0 = 1'b1; dn1 = 1'b1;
    tick();
    chk("pad0_step", dut.pad_row0, 296);
    chk("pad1_step", dut.pad_row1, 304);
    repeat (49) tick();
    dn1 = 1'b0;
    chk("pad1_500", dut.pad_row1, 500);
    chk("pad0_100", dut.pad_row0, 100);
    repeat (19) tick();
    chk("pad0_24", dut.pad_row0, 24);
    tick();
    chk("pad0_clamp", dut.pad_row0, 22);
    repeat (10) tick();
    chk("pad0_held_at_limit", dut.pad_row0, 22);
    dn0 = 1'b1;
    repeat (3) tick();
    chk("pad0_both_hold", dut.pad_row0, 22);
    up0 = 1'b0; dn0 = 1'b0;
    pix("px_pad0_top", 10, 0, 8'hFF);
    pix("px_pad0_below", 10, 44, 8'h00);

    // Serve off a non-tick cycle, 60-tick hold, launch, bottom wall
    pulse_serve();
    chk("serve_pending_idle", dut.state, IDLE);
    tick();
    chk("serve_state", dut.state, SERVE);
    repeat (59) tick();
    chk("serve_hold_state", dut.state, SERVE);
    chk("serve_hold_col", dut.ball_col, 400);
    tick();
    chk("play_state", dut.state, PLAY);
    chk("play_held_row", dut.ball_row, 300);
    tick();
    chk("move1_col", dut.ball_col, 402);
    chk("move1_row", dut.ball_row, 302);
    pulse_serve();
    tick();
    chk("serve_ignored_play", dut.state, PLAY);
    chk("move2_col", dut.ball_col, 404);
    repeat (146) tick();
    chk("pre_wall_row", dut.ball_row, 596);
    chk("pre_wall_vy", dut.vy_neg, 0);
    tick();
    chk("wall_row_snap", dut.ball_row, 596);
    chk("wall_vy_flip", dut.vy_neg, 1);
    chk("wall_col", dut.ball_col, 698);

    // Right paddle bounce
    repeat (41) tick();
    chk("pre_hit_vx", dut.vx_neg, 0);
    tick();
    chk("rhit_vx", dut.vx_neg, 1);
    chk("rhit_col", dut.ball_col, 780);
    chk("rhit_row", dut.ball_row, 512);
    chk("rhit_score_p0", score_p0, 0);

    // Left miss with paddle parked at the top
    n = 0;
    while (dut.state !== POINT && n < 600) begin tick(); n++; end
    chk("miss_point", dut.state, POINT);
    chk("miss_ticks", n, 389);
    chk("miss_ball_held", dut.ball_col, 4);
    chk("miss_score_pending", score_p1, 0);
    tick();
    chk("point_to_serve", dut.state, SERVE);
    chk("point_score_p1", score_p1, 1);
    chk("point_score_p0", score_p0, 0);
    chk("point_vx_toward_p0", dut.vx_neg, 1);
    chk("point_vy_kept", dut.vy_neg, 0);
    chk("point_recentre", dut.ball_col, 400);

    // Lower clamp on the right paddle during the serve hold
    dn1 = 1'b1;
    repeat (20) tick();
    dn1 = 1'b0;
    chk("pad1_clamp", dut.pad_row1, 577);

    // Play out to 7
    for (int r = 2; r <= 7; r++) begin
      n = 0;
      while (dut.state !== POINT && n < 400) begin tick(); n++; end
      chk("round_point", dut.state, POINT);
      tick();
      chk("round_score_p1", score_p1, r);
    end
    chk("go_state", dut.state, GAME_OVER);
    chk("go_flag", game_over, 1);
    chk("go_winner", winner, 1);
    chk("go_score_p0", score_p0, 0);
    pix("go_ball_hidden", 400, 300, 8'h00);
    pix("go_ball_hidden2", 399, 298, 8'h00);
    tick();
    chk("go_frozen", score_p1, 7);
    chk("go_stays", dut.state, GAME_OVER);
    pulse_serve();
    tick();
    chk("restart_state", dut.state, SERVE);
    chk("restart_score_p1", score_p1, 0);
    chk("restart_game_over", game_over, 0);

    // Reset during play
    repeat (62) tick();
    chk("replay_state", dut.state, PLAY);
    col = 12'd404; row = 12'd304;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_state", dut.state, IDLE);
    chk("mid_rst_rgb", rgb, 0);
    chk("mid_rst_ball_col", dut.ball_col, 400);
    chk("mid_rst_ball_row", dut.ball_row, 300);
    chk("mid_rst_pad0", dut.pad_row0, 300);
    chk("mid_rst_pad1", dut.pad_row1, 300);
    chk("mid_rst_vx", dut.vx_neg, 0);
    chk("mid_rst_vy", dut.vy_neg, 0);
    chk("mid_rst_scores", {score_p0, score_p1}, 0);
    chk("mid_rst_go", {game_over, winner}, 0);
    rst = 1'b0;

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
